// File: rtl/time_set_input_if.sv
// Button/pulse bundle between the raw push-button pins, the time-set input stage
// and the clock core. The slave modport is the input stage itself.
interface time_set_input_if;
  logic btn_min_raw;
  logic btn_hour_raw;
  logic minute_inc;
  logic hour_inc;
  logic clear_req;
  logic btn_min_level;
  logic btn_hour_level;

  modport master (
    output btn_min_raw, btn_hour_raw,
    input  minute_inc, hour_inc, clear_req, btn_min_level, btn_hour_level
  );

  modport slave (
    input  btn_min_raw, btn_hour_raw,
    output minute_inc, hour_inc, clear_req, btn_min_level, btn_hour_level
  );
endinterface

// File: rtl/time_set_input.sv
// Minute/hour set buttons -> synchronize, debounce, press/long-press/auto-repeat pulses,
// plus a both-buttons clear. Auto-repeat is built only with TIME_SET_AUTOREPEAT_EN defined.
module time_set_input #(
  parameter int unsigned DEBOUNCE_CYCLES   = 160000,
  parameter int unsigned LONG_PRESS_CYCLES = 8000000,
  parameter int unsigned REPEAT_CYCLES     = 3200000
) (
  input  logic              CLK,
  input  logic              RST_N,
  time_set_input_if.slave   bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int unsigned HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ?
                                     LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  // Index 0 is the minute button, index 1 the hour button.
  logic [1:0]      raw;
  logic [1:0]      sync_a;
  logic [1:0]      sync_b;
  logic [1:0]      level;
  logic [1:0]      level_d;
  logic [1:0]      inc;
  logic [DB_W-1:0] db_cnt [2];
  state_t          state  [2];
`ifdef TIME_SET_AUTOREPEAT_EN
  logic [HOLD_W-1:0] hold_cnt [2];
`endif
  logic            latched;
  logic            clear;
  logic            chord_trig;
  logic            hold_off;

  assign raw        = {bus.btn_hour_raw, bus.btn_min_raw};
  assign chord_trig = level[0] & level[1] & ~latched;
  // The trigger cycle itself already suppresses inc pulses and parks both FSMs.
  assign hold_off   = chord_trig | latched;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level   <= '0;
      level_d <= '0;
      inc     <= '0;
      latched <= 1'b0;
      clear   <= 1'b0;
      // NOTE: the per-button arrays are ordinary flops, not RAM, so they are reset
      // element by element to guarantee both FSMs leave reset in IDLE.
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
        state[i]  <= IDLE;
`ifdef TIME_SET_AUTOREPEAT_EN
        hold_cnt[i] <= '0;
`endif
      end
    end else begin
      // NOTE: non-blocking throughout, so the FSM acts on last cycle's debounced
      // level and level_d, giving the one-cycle pulse after the level rises.
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_d <= level;
      clear   <= chord_trig;
      latched <= chord_trig | (latched & |level);

      for (int i = 0; i < 2; i++) begin
        inc[i] <= 1'b0;

        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end

        if (hold_off) begin
          state[i] <= IDLE;
        end else begin
          case (state[i])
            IDLE: begin
              if (level[i] && !level_d[i]) begin
                inc[i]   <= 1'b1;
                state[i] <= HELD;
`ifdef TIME_SET_AUTOREPEAT_EN
                hold_cnt[i] <= '0;
`endif
              end
            end
            HELD: begin
              if (!level[i]) begin
                state[i] <= IDLE;
`ifdef TIME_SET_AUTOREPEAT_EN
              end else if (hold_cnt[i] == LONG_LAST) begin
                inc[i]      <= 1'b1;
                hold_cnt[i] <= '0;
                state[i]    <= REPEAT;
              end else begin
                hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
`endif
              end
            end
`ifdef TIME_SET_AUTOREPEAT_EN
            REPEAT: begin
              // Release is tested first so it wins over a coincident terminal count.
              if (!level[i]) begin
                state[i] <= IDLE;
              end else if (hold_cnt[i] == REPEAT_LAST) begin
                inc[i]      <= 1'b1;
                hold_cnt[i] <= '0;
              end else begin
                hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
              end
            end
`endif
            default: state[i] <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.minute_inc     = inc[0];
  assign bus.hour_inc       = inc[1];
  assign bus.clear_req      = clear;
  assign bus.btn_min_level  = level[0];
  assign bus.btn_hour_level = level[1];

endmodule
